// File: rtl/bubsys_prom_pkg.sv
// Shared constants and helpers for the wide program ROM.
package bubsys_prom_pkg;

    localparam int SUM_W = 16;

    // Number of address bits that pick a download lane inside one wide word.
    function automatic int lane_w(input int dw, input int pw);
        return $clog2(dw / pw);
    endfunction

endpackage

// File: rtl/bubsys_prom_ram.sv
// Single-clock word storage: one write port, one registered read port.
module bubsys_prom_ram #(
    parameter int    AW         = 10,
    parameter int    DW         = 16,
    parameter string simhexfile = ""
) (
    input  logic          i_CLK,
    input  logic          i_RST_n,
    input  logic          i_WE,
    input  logic [AW-1:0] i_WADDR,
    input  logic [DW-1:0] i_WDATA,
    input  logic          i_RE,
    input  logic [AW-1:0] i_RADDR,
    output logic [DW-1:0] o_Q
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [DW-1:0] r_q;

    always_ff @(posedge i_CLK) begin
        if (i_WE) r_mem[i_WADDR] <= i_WDATA;
    end

    // Output register holds its value whenever no read is enabled.
    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n)  r_q <= '0;
        else if (i_RE) r_q <= r_mem[i_RADDR];
    end

    assign o_Q = r_q;

endmodule

// File: rtl/bubsys_prom_wide.sv
// Program ROM with byte-wide download packing, lane-order check, checksum and load status.
module bubsys_prom_wide
    import bubsys_prom_pkg::*;
#(
    parameter int    AW         = 10,
    parameter int    DW         = 16,
    parameter int    PW         = 8,
    parameter string simhexfile = ""
) (
    input  logic                        i_MCLK,
    input  logic                        i_RST_n,
    input  logic [AW+lane_w(DW,PW)-1:0] i_PROG_ADDR,
    input  logic [PW-1:0]               i_PROG_DIN,
    input  logic                        i_PROG_CS,
    input  logic                        i_PROG_WR,
    input  logic [AW-1:0]               i_ADDR,
    input  logic                        i_RD,
    output logic [DW-1:0]               o_DOUT,
    output logic                        o_DVALID,
    output logic [SUM_W-1:0]            o_SUM,
    output logic                        o_PROG_ERR,
    output logic                        o_LOADED
);

    localparam int LW  = lane_w(DW, PW);
    localparam int NL  = 1 << LW;
    localparam int LWX = (LW == 0) ? 1 : LW;

    logic             r_cs;
    logic [DW-1:0]    r_stage;
    logic [LWX-1:0]   r_exp;
    logic [SUM_W-1:0] r_sum;
    logic             r_err;
    logic             r_commit;
    logic             r_loaded;
    logic             r_dvalid;

    logic             w_rise;
    logic             w_fall;
    logic             w_wr;
    logic             w_rd;
    logic [LWX-1:0]   w_lane;
    logic [LWX-1:0]   w_exp_base;
    logic [SUM_W-1:0] w_sum_base;
    logic [AW-1:0]    w_word;
    logic [DW-1:0]    w_merged;
    logic             w_last;
    logic             w_we;

    assign w_rise = i_PROG_CS & ~r_cs;
    assign w_fall = ~i_PROG_CS & r_cs;
    assign w_wr   = i_PROG_CS & i_PROG_WR;
    assign w_rd   = ~i_PROG_CS & i_RD;
    assign w_word = i_PROG_ADDR[AW+LW-1:LW];

    generate
        if (LW == 0) begin : g_nolane
            assign w_lane = '0;
        end else begin : g_lane
            assign w_lane = i_PROG_ADDR[LW-1:0];
        end
    endgenerate

    // A session start clears state in the same cycle a write may land, so
    // the write merges into the cleared values rather than the stale ones.
    assign w_exp_base = w_rise ? '0 : r_exp;
    assign w_sum_base = w_rise ? '0 : r_sum;

    always_comb begin
        w_merged = w_rise ? '0 : r_stage;
        for (int l = 0; l < NL; l++) begin
            if (w_lane == LWX'(l)) w_merged[l*PW +: PW] = i_PROG_DIN;
        end
    end

    assign w_last = (w_lane == LWX'(NL - 1));
    assign w_we   = w_wr & w_last;

    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            r_cs     <= 1'b0;
            r_stage  <= '0;
            r_exp    <= '0;
            r_sum    <= '0;
            r_err    <= 1'b0;
            r_commit <= 1'b0;
            r_loaded <= 1'b0;
            r_dvalid <= 1'b0;
        end else begin
            r_cs     <= i_PROG_CS;
            r_dvalid <= w_rd;
            if (w_rise) begin
                r_stage  <= '0;
                r_exp    <= '0;
                r_sum    <= '0;
                r_err    <= 1'b0;
                r_commit <= 1'b0;
                r_loaded <= 1'b0;
            end
            if (w_wr) begin
                r_sum   <= w_sum_base + SUM_W'(i_PROG_DIN);
                r_exp   <= (LW == 0) ? '0 : w_lane + 1'b1;
                r_stage <= w_last ? '0 : w_merged;
                if (w_lane != w_exp_base) r_err <= 1'b1;
                if (w_last) r_commit <= 1'b1;
            end
            // Any staged partial word is simply dropped at session end.
            if (w_fall) r_loaded <= r_commit & ~r_err;
        end
    end

    bubsys_prom_ram #(
        .AW         (AW),
        .DW         (DW),
        .simhexfile (simhexfile)
    ) u_ram (
        .i_CLK   (i_MCLK),
        .i_RST_n (i_RST_n),
        .i_WE    (w_we),
        .i_WADDR (w_word),
        .i_WDATA (w_merged),
        .i_RE    (w_rd),
        .i_RADDR (i_ADDR),
        .o_Q     (o_DOUT)
    );

    assign o_DVALID   = r_dvalid;
    assign o_SUM      = r_sum;
    assign o_PROG_ERR = r_err;
    assign o_LOADED   = r_loaded;

endmodule

// File: tb/tb_bubsys_prom_wide.sv
// Scoreboard bench for bubsys_prom_wide: byte-level session model plus word-store model.
module tb_bubsys_prom_wide;

    localparam int AW  = 6;
    localparam int DW  = 16;
    localparam int PW  = 8;
    localparam int LW  = 1;
    localparam int NL  = 2;
    localparam int PAW = AW + LW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic [PAW-1:0] prog_addr;
    logic [7:0]     din;
    logic           cs, wr, rd;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  dout;
    logic           dvalid;
    logic [15:0]    sum;
    logic           err, loaded;

    logic [3:0]  p8_addr;
    logic [7:0]  p8_din;
    logic        p8_cs, p8_wr, rd8;
    logic [3:0]  a8;
    logic [7:0]  dout8;
    logic        dv8;
    logic [15:0] sum8;
    logic        err8, ld8;

    bubsys_prom_wide #(.AW(AW), .DW(DW), .PW(PW)) dut (
        .i_MCLK(clk), .i_RST_n(rst_n), .i_PROG_ADDR(prog_addr), .i_PROG_DIN(din),
        .i_PROG_CS(cs), .i_PROG_WR(wr), .i_ADDR(addr), .i_RD(rd),
        .o_DOUT(dout), .o_DVALID(dvalid), .o_SUM(sum), .o_PROG_ERR(err), .o_LOADED(loaded)
    );

    bubsys_prom_wide #(.AW(4), .DW(8), .PW(8)) dut8 (
        .i_MCLK(clk), .i_RST_n(rst_n), .i_PROG_ADDR(p8_addr), .i_PROG_DIN(p8_din),
        .i_PROG_CS(p8_cs), .i_PROG_WR(p8_wr), .i_ADDR(a8), .i_RD(rd8),
        .o_DOUT(dout8), .o_DVALID(dv8), .o_SUM(sum8), .o_PROG_ERR(err8), .o_LOADED(ld8)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mon_e;

    // Reference model: byte lanes of the word being assembled, session status, word store.
    logic [7:0]    m_stage[NL];
    int            m_exp, m_sum;
    bit            m_err, m_commit, m_loaded;
    logic [DW-1:0] mem_model[int];

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && dvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rd_unexpected: got dvalid=1 dout=%0h expected no read result", dout);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rd_data", {16'h0, dout}, {16'h0, mon_e});
            end
        end
    end

    function automatic void m_start();
        for (int l = 0; l < NL; l++) m_stage[l] = 8'h00;
        m_exp = 0; m_sum = 0; m_err = 0; m_commit = 0; m_loaded = 0;
    endfunction

    function automatic void m_write(int a, int d);
        int lane, word;
        logic [DW-1:0] w;
        lane = a % NL;
        word = a / NL;
        if (lane != m_exp) m_err = 1;
        m_exp = (lane + 1) % NL;
        m_sum = (m_sum + d) % 65536;
        m_stage[lane] = d[7:0];
        if (lane == NL - 1) begin
            w = '0;
            for (int l = 0; l < NL; l++) w = w | (DW'(m_stage[l]) << (8 * l));
            mem_model[word] = w;
            m_commit = 1;
            for (int l = 0; l < NL; l++) m_stage[l] = 8'h00;
        end
    endfunction

    task automatic cs_up();
        cs = 1; wr = 0; m_start();
        @(posedge clk); #1;
    endtask

    task automatic cs_up_wr(int a, int d);
        cs = 1; wr = 1; prog_addr = PAW'(a); din = d[7:0];
        m_start(); m_write(a, d);
        @(posedge clk); #1;
        wr = 0;
    endtask

    task automatic wbyte(int a, int d);
        prog_addr = PAW'(a); din = d[7:0]; wr = 1;
        m_write(a, d);
        @(posedge clk); #1;
        wr = 0;
    endtask

    task automatic cs_down();
        cs = 0; wr = 0;
        @(posedge clk); #1;
        m_loaded = m_commit & ~m_err;
        @(posedge clk); #1;
    endtask

    task automatic chk_status(string tag);
        chk({tag, "_sum"}, {16'h0, sum}, 32'(m_sum));
        chk({tag, "_err"}, {31'h0, err}, {31'h0, m_err});
        chk({tag, "_loaded"}, {31'h0, loaded}, {31'h0, m_loaded});
    endtask

    task automatic rd_word(int a);
        rd = 1; addr = AW'(a);
        exp_q.push_back(mem_model[a]);
        @(posedge clk); #1;
        rd = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic rd_burst(int n);
        int a;
        for (int i = 0; i < n; i++) begin
            a = int'($urandom % (1 << AW));
            for (int t = 0; t < 64 && !mem_model.exists(a); t++) a = (a + 1) % (1 << AW);
            rd = 1; addr = AW'(a);
            exp_q.push_back(mem_model[a]);
            @(posedge clk); #1;
        end
        rd = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] hold;
        int w0, nw, lane, a;
        bit first, rise_wr, inject;

        rst_n = 0; cs = 0; wr = 0; rd = 0; prog_addr = '0; din = '0; addr = '0;
        p8_addr = '0; p8_din = '0; p8_cs = 0; p8_wr = 0; a8 = '0; rd8 = 0;
        m_start();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", {16'h0, dout}, 32'h0);
        chk("rst_dvalid", {31'h0, dvalid}, 32'h0);
        chk_status("rst");
        rst_n = 1;
        @(posedge clk); #1;

        // Sequential load
        cs_up();
        wbyte(0, 'h34); wbyte(1, 'h12); wbyte(2, 'h78); wbyte(3, 'h56);
        cs_down();
        chk("seq_sum", {16'h0, sum}, 32'h0114);
        chk("seq_loaded", {31'h0, loaded}, 32'h1);
        chk("seq_err", {31'h0, err}, 32'h0);
        rd_word(0);
        rd_word(1);

        // Lane order error
        cs_up();
        wbyte(11, 'h21); wbyte(10, 'h43); wbyte(11, 'h65);
        chk("lane_err_live", {31'h0, err}, 32'h1);
        cs_down();
        chk_status("lane");
        chk("lane_loaded", {31'h0, loaded}, 32'h0);
        rd_word(5);

        // Read blocked while a session is open
        cs_up();
        hold = dout;
        rd = 1; addr = '0;
        @(posedge clk); #1;
        rd = 0;
        @(negedge clk);
        chk("blk_dvalid", {31'h0, dvalid}, 32'h0);
        chk("blk_dout_hold", {16'h0, dout}, {16'h0, hold});
        @(posedge clk); #1;
        cs_down();
        rd_word(0);

        // Partial word discarded
        cs_up();
        wbyte(4, 'hAA); wbyte(5, 'hAA);
        cs_down();
        cs_up();
        wbyte(4, 'h11);
        cs_down();
        chk("part_loaded", {31'h0, loaded}, 32'h0);
        chk("part_sum", {16'h0, sum}, 32'h0011);
        rd_word(2);

        // Asynchronous reset in mid-session
        cs_up();
        wbyte(0, 'hC3); wbyte(1, 'h5A); wbyte(2, 'h77);
        #2;
        rst_n = 0; cs = 0;
        #1;
        m_start();
        chk("arst_dout", {16'h0, dout}, 32'h0);
        chk("arst_dvalid", {31'h0, dvalid}, 32'h0);
        chk_status("arst");
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        rd_word(0);
        chk("arst_loaded_after", {31'h0, loaded}, 32'h0);

        // Randomized sessions
        for (int s = 0; s < 24; s++) begin
            w0      = int'($urandom % (1 << AW));
            nw      = 1 + int'($urandom % 3);
            rise_wr = ($urandom % 3) == 0;
            inject  = ($urandom % 4) == 0;
            first   = 1;
            if (!rise_wr) cs_up();
            for (int k = 0; k < nw; k++) begin
                for (int l = 0; l < NL; l++) begin
                    lane = (inject && ($urandom % 3) == 0) ? int'($urandom % NL) : l;
                    a = ((w0 + k) % (1 << AW)) * NL + lane;
                    if (first && rise_wr) cs_up_wr(a, int'($urandom % 256));
                    else wbyte(a, int'($urandom % 256));
                    first = 0;
                end
            end
            if (($urandom % 4) == 0) wbyte(((w0 + nw) % (1 << AW)) * NL, int'($urandom % 256));
            cs_down();
            chk_status("rnd");
            rd_burst(1 + int'($urandom % 4));
        end

        // Checksum wrap with packing disabled
        p8_cs = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 'h102; i++) begin
            p8_addr = 4'(i); p8_din = 8'hFF; p8_wr = 1;
            @(posedge clk); #1;
        end
        p8_wr = 0; p8_cs = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("wrap_sum", {16'h0, sum8}, 32'h00FE);
        chk("wrap_err", {31'h0, err8}, 32'h0);
        chk("wrap_loaded", {31'h0, ld8}, 32'h1);
        a8 = 4'd3; rd8 = 1;
        @(posedge clk); #1;
        rd8 = 0;
        chk("wrap_dvalid", {31'h0, dv8}, 32'h1);
        chk("wrap_dout", {24'h0, dout8}, 32'hFF);

        for (int t = 0; t < 10 && exp_q.size() != 0; t++) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rd_drain: got %0d reads outstanding expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
